// File: rtl/priority_encoder_4x2_pkg.sv
// ----------------------------------------------------------------------------
// encoder_pkg
//
// Shared definitions for the registered 4-to-2 priority encoder and its
// combinational priority picker.
//
// Contents:
//   CODE_W         - width of the encoded request index (2)
//   N_REQ          - number of request lines (4)
//   enc_state_t    - issue FSM states: IDLE (no code out), PRESENT (code held)
//   code_to_onehot - expands an encoded index into a one-hot request mask
// ----------------------------------------------------------------------------
package encoder_pkg;

  localparam int CODE_W = 2;
  localparam int N_REQ  = 4;

  // IDLE: nothing presented, waiting for a pending request to issue.
  // PRESENT: a code is on A with valid high, waiting for ready.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } enc_state_t;

  // Turns the served index into the mask of the pending bit it retires.
  function automatic logic [N_REQ-1:0] code_to_onehot(input logic [CODE_W-1:0] code);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << code;
  endfunction

endpackage : encoder_pkg

// File: rtl/priority_encoder_4x2_if.sv
// ----------------------------------------------------------------------------
// priority_encoder_4x2_if
//
// Request/handshake bundle between the request sources plus code consumer
// (master side) and the priority encoder (slave side).
//
// Signals:
//   E       - enable; gates request capture and issue of a new code
//   D       - request lines, multi-hot, level-sampled every cycle
//   ready   - consumer accepts the presented code when high with valid
//   A       - encoded index of the request being served
//   valid   - A holds a code awaiting acceptance
//   pending - captured, not-yet-served requests
//
// Modports:
//   master - environment: drives E, D, ready; observes A, valid, pending
//   slave  - encoder: observes E, D, ready; drives A, valid, pending
// ----------------------------------------------------------------------------
interface priority_encoder_4x2_if;
  import encoder_pkg::*;

  logic              E;
  logic [N_REQ-1:0]  D;
  logic              ready;
  logic [CODE_W-1:0] A;
  logic              valid;
  logic [N_REQ-1:0]  pending;

  modport master (
    output E,
    output D,
    output ready,
    input  A,
    input  valid,
    input  pending
  );

  modport slave (
    input  E,
    input  D,
    input  ready,
    output A,
    output valid,
    output pending
  );

endinterface : priority_encoder_4x2_if

// File: rtl/priority_encoder_4x2_prio_pick4.sv
// ----------------------------------------------------------------------------
// prio_pick4
//
// Purely combinational priority pick over four request bits.
//
// Parameters:
//   HIGH_FIRST - 1: highest set index wins; 0: lowest set index wins
// Ports:
//   req [3:0] in  - request vector to pick from
//   idx [1:0] out - index of the winning request (0 when req is empty)
//   any       out - at least one request bit is set
//
// idx is only meaningful while any is high; callers must gate on any so
// that an empty vector never turns into an issued code.
// ----------------------------------------------------------------------------
module prio_pick4
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] idx,
  output logic              any
);

  // The scan direction is chosen so that the winning bit is the last one
  // visited: ascending for high-first, descending for low-first. Later
  // hits overwrite earlier ones, which leaves the priority winner in idx.
  always_comb begin
    idx = '0;
    any = |req;
    if (HIGH_FIRST) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req[i]) begin
          idx = CODE_W'(i);
        end
      end
    end else begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) begin
          idx = CODE_W'(i);
        end
      end
    end
  end

endmodule : prio_pick4

// File: rtl/priority_encoder_4x2.sv
// ----------------------------------------------------------------------------
// priority_encoder_4x2
//
// Registered 4-to-2 priority encoder with request latching and a
// valid/ready output handshake. Requests on D are accumulated into a
// pending register and served one at a time: the priority winner of
// pending is presented as A with valid, and held until the consumer
// raises ready. Accepting retires that pending bit, and the FSM spends one
// cycle in IDLE before the next code, so at most one code every 2 cycles.
//
// Parameters:
//   HIGH_FIRST - 1: bit 3 has highest priority; 0: bit 0 has highest
// Ports:
//   clk   in  - single clock, all state updates on the rising edge
//   rst_n in  - synchronous active-low reset
//   bus       - priority_encoder_4x2_if.slave (E, D, ready in;
//               A, valid, pending out)
//
// Timing: D sampled at edge k is in pending after edge k; an idle encoder
// raises valid with A after edge k+1. valid and A are registered and never
// depend combinationally on ready, so the consumer may derive ready from
// valid/A without creating a loop.
// ----------------------------------------------------------------------------
module priority_encoder_4x2
  import encoder_pkg::*;
#(
  parameter bit HIGH_FIRST = 1'b1
) (
  input logic                  clk,
  input logic                  rst_n,
  priority_encoder_4x2_if.slave bus
);

  enc_state_t        state_q;
  logic [CODE_W-1:0] a_q;
  logic              valid_q;
  logic [N_REQ-1:0]  pending_q;

  logic [CODE_W-1:0] pick_idx;
  logic              pick_any;
  logic              accept;
  logic [N_REQ-1:0]  clr;
  logic [N_REQ-1:0]  pending_next;

  // The issue decision looks at the registered pending set, so a request
  // captured at edge k can be issued no earlier than edge k+1.
  prio_pick4 #(
    .HIGH_FIRST (HIGH_FIRST)
  ) u_pick (
    .req (pending_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign accept = valid_q & bus.ready;
  assign clr    = accept ? code_to_onehot(a_q) : '0;

  // Clear is applied before the new requests are OR-ed in, so a request
  // for the code being accepted in the same cycle keeps its pending bit
  // set and is served again later. With E low, D is ignored but an
  // accepted code is still retired.
  always_comb begin
    pending_next = pending_q & ~clr;
    if (bus.E) begin
      pending_next = pending_next | bus.D;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_next;
    end
  end

  // Issue FSM. In PRESENT, A and valid are frozen regardless of E, D or
  // pending changes: a higher-priority arrival never preempts the code on
  // the bus. Leaving PRESENT always passes through IDLE, which is the
  // one-cycle valid-low bubble between consecutive codes. Reset drops a
  // code in flight without any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.E && pick_any) begin
            a_q     <= pick_idx;
            valid_q <= 1'b1;
            state_q <= PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.A       = a_q;
  assign bus.valid   = valid_q;
  assign bus.pending = pending_q;

  // A presented code stays put until it is accepted.
  property p_hold_until_ready;
    @(posedge clk) disable iff (!rst_n)
      (valid_q && !bus.ready) |=> (valid_q && $stable(a_q));
  endproperty
  a_hold_until_ready : assert property (p_hold_until_ready);

  // Every accept is followed by at least one valid-low cycle.
  property p_bubble_after_accept;
    @(posedge clk) disable iff (!rst_n)
      accept |=> !valid_q;
  endproperty
  a_bubble_after_accept : assert property (p_bubble_after_accept);

  // valid is the registered image of the PRESENT state.
  property p_valid_matches_state;
    @(posedge clk) disable iff (!rst_n)
      valid_q == (state_q == PRESENT);
  endproperty
  a_valid_matches_state : assert property (p_valid_matches_state);

  // An empty pending set never issues a code.
  property p_no_empty_issue;
    @(posedge clk) disable iff (!rst_n)
      (!valid_q && pending_q == '0) |=> !valid_q;
  endproperty
  a_no_empty_issue : assert property (p_no_empty_issue);

endmodule : priority_encoder_4x2

// File: tb/tb_priority_encoder_4x2.sv
// ----------------------------------------------------------------------------
// tb_priority_encoder_4x2
//
// Drives one high-first and one low-first encoder with identical stimulus
// and compares both against a cycle-level reference model of the request
// set, the presented code and the handshake. Directed scenarios are
// followed by a randomized run with occasional resets.
// ----------------------------------------------------------------------------
module tb_priority_encoder_4x2;
  import encoder_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  priority_encoder_4x2_if bus_hi ();
  priority_encoder_4x2_if bus_lo ();

  priority_encoder_4x2 #(
    .HIGH_FIRST (1'b1)
  ) dut_hi (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_hi)
  );

  priority_encoder_4x2 #(
    .HIGH_FIRST (1'b0)
  ) dut_lo (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_lo)
  );

  int errors = 0;
  int checks = 0;

  // Reference model, index 0 = high-first encoder, 1 = low-first encoder.
  // The request set is a plain array of flags; the presented code is an
  // integer with a separate "presented" flag.
  bit m_pend    [2][N_REQ];
  int m_code    [2];
  bit m_valid   [2];

  // Codes seen rising on valid, per encoder, for order checks.
  int issued_hi [$];
  int issued_lo [$];
  bit last_valid_hi;
  bit last_valid_lo;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Winner among the model's pending flags, -1 when nothing is pending.
  function automatic int pick_code(input int s);
    int best;
    best = -1;
    if (s == 0) begin
      for (int i = N_REQ - 1; i >= 0; i--)
        if (m_pend[s][i] && best < 0) best = i;
    end else begin
      for (int i = 0; i < N_REQ; i++)
        if (m_pend[s][i] && best < 0) best = i;
    end
    return best;
  endfunction

  function automatic logic [N_REQ-1:0] pend_word(input int s);
    logic [N_REQ-1:0] w;
    for (int i = 0; i < N_REQ; i++) w[i] = m_pend[s][i];
    return w;
  endfunction

  // One rising edge of the model with the inputs sampled at that edge.
  task automatic model_edge(input bit r, input bit e, input logic [N_REQ-1:0] d,
                            input bit rdy);
    for (int s = 0; s < 2; s++) begin
      if (!r) begin
        for (int i = 0; i < N_REQ; i++) m_pend[s][i] = 1'b0;
        m_code[s]  = 0;
        m_valid[s] = 1'b0;
      end else begin
        int issue;
        bit taken;
        issue = -1;
        taken = m_valid[s] && rdy;
        if (!m_valid[s] && e) issue = pick_code(s);
        for (int i = 0; i < N_REQ; i++) begin
          if (taken && m_code[s] == i) m_pend[s][i] = 1'b0;
          if (e && d[i]) m_pend[s][i] = 1'b1;
        end
        if (taken) begin
          m_valid[s] = 1'b0;
        end else if (issue >= 0) begin
          m_valid[s] = 1'b1;
          m_code[s]  = issue;
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then
  // compare both encoders at the following falling edge.
  task automatic apply_stimulus(input bit r, input bit e, input logic [N_REQ-1:0] d,
                                input bit rdy);
    rst_n        = r;
    bus_hi.E     = e;
    bus_lo.E     = e;
    bus_hi.D     = d;
    bus_lo.D     = d;
    bus_hi.ready = rdy;
    bus_lo.ready = rdy;
    @(posedge clk);
    model_edge(r, e, d, rdy);
    @(negedge clk);
    check_output("valid_hi", 32'(bus_hi.valid), 32'(m_valid[0]));
    check_output("pending_hi", 32'(bus_hi.pending), 32'(pend_word(0)));
    check_output("valid_lo", 32'(bus_lo.valid), 32'(m_valid[1]));
    check_output("pending_lo", 32'(bus_lo.pending), 32'(pend_word(1)));
    if (m_valid[0] || !r) check_output("A_hi", 32'(bus_hi.A), 32'(m_code[0]));
    if (m_valid[1] || !r) check_output("A_lo", 32'(bus_lo.A), 32'(m_code[1]));
    if (bus_hi.valid && !last_valid_hi) issued_hi.push_back(int'(bus_hi.A));
    if (bus_lo.valid && !last_valid_lo) issued_lo.push_back(int'(bus_lo.A));
    last_valid_hi = bus_hi.valid;
    last_valid_lo = bus_lo.valid;
  endtask

  task automatic check_seq(input string tag, input int got[$], input int want[$]);
    check_output({tag, "_count"}, 32'(got.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++) begin
      check_output({tag, "_code"}, (i < got.size()) ? 32'(got[i]) : 32'hffff_ffff,
                   32'(want[i]));
    end
  endtask

  initial begin
    int want_hi [$];
    int want_lo [$];
    last_valid_hi = 1'b0;
    last_valid_lo = 1'b0;

    // Reset for two cycles.
    apply_stimulus(1'b0, 1'b0, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b0, 4'b0000, 1'b0);

    // Basic issue: a single request, code 2 two cycles after the sample.
    issued_hi.delete();
    issued_lo.delete();
    apply_stimulus(1'b1, 1'b1, 4'b0100, 1'b1);
    check_output("basic_no_early_valid", 32'(bus_hi.valid), 32'd0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    check_output("basic_valid", 32'(bus_hi.valid), 32'd1);
    check_output("basic_code", 32'(bus_hi.A), 32'd2);
    repeat (3) apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    check_output("basic_pending_empty", 32'(bus_hi.pending), 32'd0);

    // Priority order from one multi-hot burst.
    issued_hi.delete();
    issued_lo.delete();
    apply_stimulus(1'b1, 1'b1, 4'b1011, 1'b1);
    repeat (8) apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    want_hi = {3, 1, 0};
    want_lo = {0, 1, 3};
    check_seq("prio_hi", issued_hi, want_hi);
    check_seq("prio_lo", issued_lo, want_lo);

    // Back-pressure with a higher request arriving during the stall.
    issued_hi.delete();
    issued_lo.delete();
    apply_stimulus(1'b1, 1'b1, 4'b0010, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b1000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    check_output("stall_code_held", 32'(bus_hi.A), 32'd1);
    repeat (6) apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    want_hi = {1, 3};
    check_seq("stall_hi", issued_hi, want_hi);
    check_seq("stall_lo", issued_lo, want_hi);

    // Set wins over clear on the code being accepted.
    issued_hi.delete();
    issued_lo.delete();
    apply_stimulus(1'b1, 1'b1, 4'b0001, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0001, 1'b1);
    check_output("setwins_pending", 32'(bus_hi.pending), 32'h1);
    repeat (4) apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b1);
    want_hi = {0, 0};
    check_seq("setwins_hi", issued_hi, want_hi);

    // Enable gating: D ignored, presented code still completes.
    apply_stimulus(1'b1, 1'b1, 4'b0100, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0);
    apply_stimulus(1'b1, 1'b0, 4'b1111, 1'b0);
    check_output("gate_pending", 32'(bus_hi.pending), 32'h4);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    apply_stimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    check_output("gate_no_issue", 32'(bus_hi.valid), 32'd0);

    // Reset mid-operation with a code presented and two requests pending.
    apply_stimulus(1'b1, 1'b1, 4'b0110, 1'b0);
    apply_stimulus(1'b1, 1'b1, 4'b0000, 1'b0);
    apply_stimulus(1'b0, 1'b1, 4'b1111, 1'b1);
    check_output("midreset_valid", 32'(bus_hi.valid), 32'd0);
    check_output("midreset_pending", 32'(bus_lo.pending), 32'd0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      bit               r;
      bit               e;
      bit               rdy;
      logic [N_REQ-1:0] d;
      r   = ($urandom_range(0, 49) != 0);
      e   = ($urandom_range(0, 7) != 0);
      d   = ($urandom_range(0, 2) == 0) ? N_REQ'($urandom) : '0;
      rdy = ($urandom_range(0, 2) != 0);
      apply_stimulus(r, e, d, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_priority_encoder_4x2

// File: doc/priority_encoder_4x2.md
# priority_encoder_4x2

Registered 4-to-2 priority encoder with request latching and a valid/ready output handshake. It is the encode-side counterpart of the 2x4 decoder: four request lines are captured into a pending register and served one at a time as a 2-bit code plus valid. Codes are held stable until the consumer accepts them. Intended between interrupt/request sources and a consumer that drives a 2x4 decoder from the returned code.

## Interface
- `HIGH_FIRST`, default 1: 1 = bit 3 has highest priority; 0 = bit 0 has highest priority.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `E` in 1: enable; gates request capture and new code issue.
- `D` in 4: request lines, multi-hot allowed, level-sampled each cycle.
- `ready` in 1: consumer accepts the current code when high together with `valid`.
- `A` out 2: encoded index of the request being served.
- `valid` out 1: `A` holds a code awaiting acceptance.
- `pending` out 4: registered set of captured, not-yet-served requests.

## Operation
- Pending register update at each edge with `E`=1: `pending <= (pending & ~clr) | D`.
  - `clr` is the one-hot of `A` when `valid & ready`, otherwise 0.
- With `E`=0: `D` is ignored, giving `pending <= pending & ~clr`.
- FSM states:
  - IDLE: `valid`=0.
    - Transition: if `E`=1 and `pending`≠0, load `A` with the priority pick of `pending`, set `valid`=1, go to PRESENT.
    - Otherwise stay in IDLE.
  - PRESENT: `valid`=1; `A` and `valid` hold unchanged regardless of `E`, `D` or changes in `pending`.
    - Transition: on `ready`=1, clear `pending[A]`, set `valid`=0, go to IDLE.
- Priority pick:
  - `HIGH_FIRST`=1: the highest set index.
  - `HIGH_FIRST`=0: the lowest set index.
  - `pending`=0 never produces an issue.
- Simultaneous events:
  - Set wins over clear: if `D[A]`=1 with `E`=1 in the accept cycle, `pending[A]` stays 1 and is served again later.
  - A higher-priority request arriving during PRESENT does not preempt. It is served on the next issue.
- Repeated assertion of an already pending bit has no further effect; requests do not count.

## Timing
- Reset value of every output (`rst_n` low at an edge): `A`=2'b00, `valid`=0, `pending`=4'b0000. FSM goes to IDLE.
  - A code in flight is dropped, with no handshake.
  - `rst_n` has priority over `E`, `D` and `ready`.
- Latency:
  - `D` sampled at edge k sets `pending` after edge k.
  - If IDLE, `valid`/`A` go high after edge k+1.
  - Request-to-valid is therefore 2 cycles.
- Acceptance takes effect at the edge where `valid & ready`=1. `valid` is low for at least one cycle (the IDLE bubble) before the next code.
- Maximum throughput: one code per 2 cycles.
- `ready` high while `valid`=0 is ignored.
- `ready` may depend combinationally on `valid`/`A`. `valid` must not depend combinationally on `ready`.

## Structure
- Shared package `encoder_pkg`:
  - FSM state typedef: IDLE, PRESENT.
  - `CODE_W`=2.
  - `N_REQ`=4.
- One combinational sub-module, `prio_pick4`:
  - Inputs: `req[3:0]` and `HIGH_FIRST`.
  - Outputs: `idx[1:0]` and `any`.
  - Reused by the FSM for the issue decision.
- Rest of the block is the top level: pending register, FSM, output registers.

## Test plan
- Reset and basic issue: `rst_n`=0 for 2 cycles, then `E`=1, `D`=4'b0100 for 1 cycle, `ready`=1 → `valid`=1 with `A`=2'b10 exactly 2 cycles after the sample. Then `pending`=0 and `valid`=0 after accept.
- Priority order (`HIGH_FIRST`=1): `D`=4'b1011 for 1 cycle, `ready`=1 → codes 3, 1, 0 in that order, each separated by one `valid`=0 cycle.
- Back-pressure: `D`=4'b0010, `ready`=0 for 5 cycles, `D`=4'b1000 pulsed during the stall → `A`=2'b01 held stable with `valid`=1 throughout. After `ready`=1, the next code is 3.
- Set-wins collision: while `A`=2'b00 is presented, drive `ready`=1 and `D`=4'b0001 in the same cycle → `pending[0]` remains 1 and code 0 is issued again.
- Enable gating: `E`=0 with `D`=4'b1111 → `pending` unchanged and no new issue. A code already presented still completes on `ready`.
- Reset mid-operation: `rst_n`=0 while `valid`=1 and `pending`=4'b0110 → the next cycle shows `valid`=0, `A`=0, `pending`=0.
